// File: rtl/cgra_conf_dispatch_ctrl.sv
// Sequences one CGRA configuration/run episode: streams host config words onto the
// switch broadcast bus, waits a drain gap, then enables the PC network for N thread rounds.
module cgra_conf_dispatch_ctrl #(
    parameter int unsigned CONF_WIDTH   = 64,
    parameter int unsigned NUM_THREADS  = 7,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic [CNT_WIDTH-1:0]  num_rounds,
    input  logic                  stall,
    input  logic                  conf_in_valid,
    input  logic [CONF_WIDTH-1:0] conf_in_data,
    output logic                  conf_in_ready,
    output logic [CONF_WIDTH-1:0] conf_bus_out,
    output logic                  en_pc_net,
    output logic [2:0]            thread_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned TW = 3;
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [CNT_WIDTH-1:0] words_q;
    logic [CNT_WIDTH-1:0] rounds_q;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic [CNT_WIDTH-1:0] round_cnt;
    logic [TW-1:0]        slot;
    logic [DW-1:0]        drain_cnt;

    logic accept;
    logic last_word;
    logic drain_last;
    logic fire;
    logic last_slot;
    logic last_fire;

    // Abort masks ready so a word offered in the abort cycle is never taken.
    assign conf_in_ready = (state == S_LOAD) && !abort;
    assign accept        = conf_in_ready && conf_in_valid;
    assign last_word     = (word_cnt == (words_q - CNT_WIDTH'(1)));
    assign drain_last    = (drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign fire          = (state == S_RUN) && !stall && !abort;
    assign last_slot     = (slot == TW'(NUM_THREADS - 1));
    assign last_fire     = fire && last_slot && (round_cnt == (rounds_q - CNT_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (num_words != '0) ? S_LOAD : S_DRAIN;
                end
            end
            S_LOAD: begin
                if (accept && last_word) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    next_state = (rounds_q != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (last_fire) begin
                    next_state = S_FIN;
                end
            end
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
        end
    end

    // Registered outputs and episode counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_bus_out <= '0;
            en_pc_net    <= 1'b0;
            thread_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_q      <= '0;
            rounds_q     <= '0;
            word_cnt     <= '0;
            round_cnt    <= '0;
            slot         <= '0;
            drain_cnt    <= '0;
        end else begin
            conf_bus_out <= accept ? conf_in_data : '0;
            en_pc_net    <= fire;
            busy         <= (next_state != S_IDLE);
            done         <= (state == S_FIN) && !abort;
            if (abort) begin
                thread_idx <= '0;
                words_q    <= '0;
                rounds_q   <= '0;
                word_cnt   <= '0;
                round_cnt  <= '0;
                slot       <= '0;
                drain_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            words_q   <= num_words;
                            rounds_q  <= num_rounds;
                            word_cnt  <= '0;
                            round_cnt <= '0;
                            slot      <= '0;
                            drain_cnt <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            word_cnt <= last_word ? '0 : word_cnt + CNT_WIDTH'(1);
                        end
                    end
                    S_DRAIN: begin
                        drain_cnt <= drain_last ? '0 : drain_cnt + DW'(1);
                    end
                    S_RUN: begin
                        if (fire) begin
                            thread_idx <= slot;
                            slot       <= last_slot ? '0 : slot + TW'(1);
                            if (last_slot) begin
                                round_cnt <= round_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    S_FIN: begin
                        thread_idx <= '0;
                        slot       <= '0;
                        round_cnt  <= '0;
                    end
                    default: begin
                        thread_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cgra_conf_dispatch_ctrl.sv
// Scoreboard bench for cgra_conf_dispatch_ctrl: episode model predicts cycle-stamped
// bus words, enable slots and done pulses; a negedge monitor pops and compares them.
module tb_cgra_conf_dispatch_ctrl;

    localparam int MAXK  = 512;
    localparam int MAXW  = 16;
    localparam int NT    = 7;
    localparam int DRAIN = 4;

    typedef struct packed {
        int unsigned cyc;
        logic [63:0] data;
    } bus_ev_t;

    typedef struct packed {
        int unsigned cyc;
        logic [2:0]  idx;
    } en_ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] num_words;
    logic [15:0] num_rounds;
    logic        stall;
    logic        conf_in_valid;
    logic [63:0] conf_in_data;
    logic        conf_in_ready;
    logic [63:0] conf_bus_out;
    logic        en_pc_net;
    logic [2:0]  thread_idx;
    logic        busy;
    logic        done;

    int unsigned cyc = 0;
    int          total = 0;
    int          passed = 0;

    bus_ev_t     exp_bus[$];
    en_ev_t      exp_en[$];
    int unsigned exp_done[$];

    cgra_conf_dispatch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .num_words     (num_words),
        .num_rounds    (num_rounds),
        .stall         (stall),
        .conf_in_valid (conf_in_valid),
        .conf_in_data  (conf_in_data),
        .conf_in_ready (conf_in_ready),
        .conf_bus_out  (conf_bus_out),
        .en_pc_net     (en_pc_net),
        .thread_idx    (thread_idx),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every visible output event must match the head of its queue.
    always @(negedge clk) begin
        bus_ev_t     be;
        en_ev_t      ee;
        int unsigned de;
        if (conf_bus_out != '0) begin
            if (exp_bus.size() == 0) check("bus_unexpected", conf_bus_out, 64'd0);
            else begin
                be = exp_bus.pop_front();
                check("bus_cycle", 64'(cyc), 64'(be.cyc));
                check("bus_data", conf_bus_out, be.data);
            end
        end
        if (en_pc_net) begin
            if (exp_en.size() == 0) check("en_unexpected", 64'(en_pc_net), 64'd0);
            else begin
                ee = exp_en.pop_front();
                check("en_cycle", 64'(cyc), 64'(ee.cyc));
                check("en_thread", 64'(thread_idx), 64'(ee.idx));
            end
        end
        if (done) begin
            if (exp_done.size() == 0) check("done_unexpected", 64'(done), 64'd0);
            else begin
                de = exp_done.pop_front();
                check("done_cycle", 64'(cyc), 64'(de));
                check("done_busy", 64'(busy), 64'd0);
            end
        end
    end

    // vmode: 0 always valid, 1 toggling 1,0,1,0,1 then steady, 2 random.
    // stall_at >= 0 stalls two cycles starting stall_at cycles into RUN.
    task automatic run_episode(input int nw, input int nr, input int vmode,
                               input int sprob, input int stall_at);
        bit          vpat[MAXK];
        bit          spat[MAXK];
        logic [63:0] words[MAXW];
        int unsigned base;
        int          acc, last_acc, d, r0, fires, fin, endk, idx;
        bus_ev_t     be;
        en_ev_t      ee;
        @(posedge clk);
        #1;
        base = cyc;
        for (int i = 0; i < MAXW; i++) words[i] = {$urandom, $urandom} | 64'h1;
        for (int c = 0; c < MAXK; c++) begin
            if (c == 0) vpat[c] = 1'b0;
            else if (vmode == 0) vpat[c] = 1'b1;
            else if (vmode == 1) vpat[c] = (c > 5) || ((c % 2) == 1);
            else vpat[c] = (c >= 100) || (int'($urandom_range(0, 99)) < 60);
        end
        acc = 0;
        last_acc = 0;
        if (nw > 0) begin
            for (int c = 1; c < MAXK && acc < nw; c++) begin
                if (vpat[c]) begin
                    be.cyc = base + c + 1;
                    be.data = words[acc];
                    exp_bus.push_back(be);
                    acc++;
                    last_acc = c;
                end
            end
            d = last_acc + 1;
        end else begin
            d = 1;
        end
        r0 = d + DRAIN;
        for (int c = 0; c < MAXK; c++) begin
            if (stall_at >= 0) spat[c] = (c == r0 + stall_at) || (c == r0 + stall_at + 1);
            else spat[c] = (c < 300) && (int'($urandom_range(0, 99)) < sprob);
        end
        fin = r0;
        if (nr > 0) begin
            fires = 0;
            for (int c = r0; c < MAXK && fires < nr * NT; c++) begin
                if (!spat[c]) begin
                    ee.cyc = base + c + 1;
                    ee.idx = 3'(fires % NT);
                    exp_en.push_back(ee);
                    fires++;
                    fin = c + 1;
                end
            end
        end
        exp_done.push_back(base + fin + 1);
        endk = fin + 2;
        idx = 0;
        for (int k = 0; k <= endk; k++) begin
            start = (k == 0);
            num_words = 16'(nw);
            num_rounds = 16'(nr);
            conf_in_valid = (k < MAXK) ? vpat[k] : 1'b0;
            conf_in_data = words[idx];
            stall = (k < MAXK) ? spat[k] : 1'b0;
            @(negedge clk);
            if (stall_at >= 1 && (k == r0 + stall_at + 1 || k == r0 + stall_at + 2))
                check("stall_hold_idx", 64'(thread_idx), 64'((stall_at - 1) % NT));
            if (conf_in_ready && conf_in_valid && idx < MAXW - 1) idx++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        conf_in_valid = 1'b0;
        stall = 1'b0;
    endtask

    // Abort after the first of four words is accepted.
    task automatic abort_load();
        bus_ev_t     be;
        logic [63:0] w0;
        @(posedge clk);
        #1;
        w0 = {$urandom, $urandom} | 64'h1;
        be.cyc = cyc + 2;
        be.data = w0;
        exp_bus.push_back(be);
        start = 1'b1;
        num_words = 16'd4;
        num_rounds = 16'd1;
        conf_in_valid = 1'b1;
        conf_in_data = w0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        conf_in_data = {$urandom, $urandom} | 64'h1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        conf_in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(conf_in_ready), 64'd0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic start_abort_same();
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        num_words = 16'd2;
        num_rounds = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 64'(busy), 64'd0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Async reset asserted mid-cycle while enables are streaming.
    task automatic reset_in_run();
        en_ev_t ee;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            ee.cyc = cyc + 6 + i;
            ee.idx = 3'(i);
            exp_en.push_back(ee);
        end
        start = 1'b1;
        num_words = 16'd0;
        num_rounds = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        start = 1'b1;
        #1;
        check("rstrun_en", 64'(en_pc_net), 64'd0);
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_idx", 64'(thread_idx), 64'd0);
        check("rstrun_bus", conf_bus_out, 64'd0);
        check("rstrun_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_words = '0;
        num_rounds = '0;
        stall = 1'b0;
        conf_in_valid = 1'b0;
        conf_in_data = '0;
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus", conf_bus_out, 64'd0);
        check("rst_en", 64'(en_pc_net), 64'd0);
        check("rst_idx", 64'(thread_idx), 64'd0);
        check("rst_ready", 64'(conf_in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_episode(3, 2, 0, 0, -1);
        run_episode(3, 1, 1, 0, -1);
        run_episode(2, 1, 0, 0, 4);
        abort_load();
        run_episode(1, 1, 0, 0, -1);
        start_abort_same();
        run_episode(0, 0, 0, 0, -1);
        for (int i = 0; i < 10; i++)
            run_episode(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 2, 25, -1);
        reset_in_run();
        run_episode(2, 2, 2, 20, -1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        check("en_queue_drained", 64'(exp_en.size()), 64'd0);
        check("done_queue_drained", 64'(exp_done.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
